button_event_capture: RTL and testbench

- Parametrised successor to the calculator's single-shot button capture.
- Synchronises and debounces NUM_BUTTONS push-buttons independently and generates press events per channel, with optional auto-repeat while a button is held.
- Arbitrates the events onto one valid/ready event port and snapshots the switch bank with each event.
- Sits between the board I/O and the calculator state machines, replacing the shared 256-cycle counter scheme.

---
 rtl/button_event_capture.sv | 196 +++++++++++++++++++
 tb/tb_button_event_capture.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_capture.sv
// Per-channel synchroniser, debouncer and auto-repeat generator feeding a
// single valid/ready event port that snapshots the switch bank with each event.
module button_event_capture #(
    parameter int NUM_BUTTONS     = 5,
    parameter int SW_BITS         = 16,
    parameter int DEBOUNCE_CYCLES = 256,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic [SW_BITS-1:0]     SW,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [NUM_BUTTONS-1:0] evt_button,
    output logic                   evt_repeat,
    output logic [SW_BITS-1:0]     evt_sw,
    output logic                   overflow
);

    localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REPEAT,
        REL_DB
    } chan_state_t;

    (* ASYNC_REG = "TRUE" *) logic [NUM_BUTTONS-1:0] sync_meta;
    (* ASYNC_REG = "TRUE" *) logic [NUM_BUTTONS-1:0] sync_s;

    logic [NUM_BUTTONS-1:0] strobe;
    logic [NUM_BUTTONS-1:0] strobe_rep;
    logic [NUM_BUTTONS-1:0] pend;
    logic [NUM_BUTTONS-1:0] pend_rep;
    logic [NUM_BUTTONS-1:0] sel;
    logic [NUM_BUTTONS-1:0] clear;
    logic                   load;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= buttons;
            sync_s    <= sync_meta;
        end
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        chan_state_t      state;
        chan_state_t      state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             chan_strobe;
        logic             chan_rep;

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;
            end
        end

        // A release always restarts its own debounce; a bounce back to 1
        // during release debounce resumes holding without a new press event.
        always_comb begin
            state_next  = state;
            cnt_next    = cnt;
            chan_strobe = 1'b0;
            chan_rep    = 1'b0;
            unique case (state)
                IDLE: begin
                    if (sync_s[i]) begin
                        state_next = PRESS_DB;
                        cnt_next   = '0;
                    end
                end
                PRESS_DB: begin
                    if (!sync_s[i]) begin
                        state_next = IDLE;
                    end else if (cnt == DB_LAST) begin
                        state_next  = HELD;
                        cnt_next    = '0;
                        chan_strobe = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!sync_s[i]) begin
                        state_next = REL_DB;
                        cnt_next   = '0;
                    end else if (REPEAT_EN != 0 && cnt == DELAY_LAST) begin
                        state_next  = REPEAT;
                        cnt_next    = '0;
                        chan_strobe = 1'b1;
                        chan_rep    = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!sync_s[i]) begin
                        state_next = REL_DB;
                        cnt_next   = '0;
                    end else if (cnt == PERIOD_LAST) begin
                        cnt_next    = '0;
                        chan_strobe = 1'b1;
                        chan_rep    = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                REL_DB: begin
                    if (sync_s[i]) begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end else if (cnt == DB_LAST) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        assign strobe[i]     = chan_strobe;
        assign strobe_rep[i] = chan_rep;
    end

    // Lowest set bit of pend wins the output register.
    always_comb begin
        load  = !evt_valid || evt_ready;
        sel   = pend & (~pend + NUM_BUTTONS'(1));
        clear = load ? sel : '0;
    end

    // A strobe landing on a pend bit that is not being drained this cycle is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            pend_rep <= '0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (strobe[i]) begin
                    if (pend[i] && !clear[i]) begin
                        overflow <= 1'b1;
                    end else begin
                        pend[i]     <= 1'b1;
                        pend_rep[i] <= strobe_rep[i];
                    end
                end else if (clear[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid  <= 1'b0;
            evt_button <= '0;
            evt_repeat <= 1'b0;
            evt_sw     <= '0;
        end else if (load) begin
            if (|pend) begin
                evt_valid  <= 1'b1;
                evt_button <= sel;
                evt_repeat <= |(sel & pend_rep);
                evt_sw     <= SW;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_capture.sv
// Scoreboard bench: one instance without auto-repeat, one with short repeat timing.
module tb_button_event_capture;

    localparam int NB  = 5;
    localparam int SWB = 16;
    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int LAT = DB + 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [SWB-1:0] sw_in;

    logic [NB-1:0]  btn_a, btn_b;
    logic           rdy_a, rdy_b;
    logic           val_a, val_b;
    logic [NB-1:0]  evb_a, evb_b;
    logic           rep_a, rep_b;
    logic [SWB-1:0] esw_a, esw_b;
    logic           ovf_a, ovf_b;

    typedef struct {
        logic [NB-1:0]  button;
        logic           rep;
        logic [SWB-1:0] sw;
        int             cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    button_event_capture #(
        .NUM_BUTTONS(NB), .SW_BITS(SWB), .DEBOUNCE_CYCLES(DB),
        .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_norep (
        .clk(clk), .rst(rst), .buttons(btn_a), .SW(sw_in),
        .evt_valid(val_a), .evt_ready(rdy_a), .evt_button(evb_a),
        .evt_repeat(rep_a), .evt_sw(esw_a), .overflow(ovf_a)
    );

    button_event_capture #(
        .NUM_BUTTONS(NB), .SW_BITS(SWB), .DEBOUNCE_CYCLES(DB),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_rep (
        .clk(clk), .rst(rst), .buttons(btn_b), .SW(sw_in),
        .evt_valid(val_b), .evt_ready(rdy_b), .evt_button(evb_b),
        .evt_repeat(rep_b), .evt_sw(esw_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit dut_b, input logic [NB-1:0] value);
        if (dut_b) btn_b = value;
        else       btn_a = value;
    endtask

    task automatic pushEvent(input bit dut_b, input logic [NB-1:0] button, input logic rep,
                             input logic [SWB-1:0] sw, input int at_cyc);
        exp_t e;
        e.button = button;
        e.rep    = rep;
        e.sw     = sw;
        e.cyc    = at_cyc;
        if (dut_b) q_b.push_back(e);
        else       q_a.push_back(e);
    endtask

    task automatic scoreEvent(input bit dut_b, input logic [NB-1:0] b, input logic r, input logic [SWB-1:0] s);
        exp_t  e;
        string pfx;
        int    size;
        pfx  = dut_b ? "rep" : "norep";
        size = dut_b ? q_b.size() : q_a.size();
        checkOutput({pfx, "_evt_expected"}, 32'(size != 0), 32'd1);
        if (size != 0) begin
            if (dut_b) e = q_b.pop_front();
            else       e = q_a.pop_front();
            checkOutput({pfx, "_evt_button"}, 32'(b), 32'(e.button));
            checkOutput({pfx, "_evt_repeat"}, 32'(r), 32'(e.rep));
            checkOutput({pfx, "_evt_sw"}, 32'(s), 32'(e.sw));
            checkOutput({pfx, "_evt_cycle"}, 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Every accepted handshake must match the head of that instance's queue.
    always @(negedge clk) begin
        if (!rst && val_a && rdy_a) scoreEvent(1'b0, evb_a, rep_a, esw_a);
        if (!rst && val_b && rdy_b) scoreEvent(1'b1, evb_b, rep_b, esw_b);
    end

    initial begin
        int c;
        int k;
        rst   = 1'b1;
        sw_in = '0;
        btn_a = '0;
        btn_b = '0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;

        tick(2);
        @(negedge clk);
        checkOutput("reset_valid_a", 32'(val_a), 32'd0);
        checkOutput("reset_ovf_a", 32'(ovf_a), 32'd0);
        checkOutput("reset_valid_b", 32'(val_b), 32'd0);
        checkOutput("reset_button_b", 32'(evb_b), 32'd0);
        checkOutput("reset_sw_b", 32'(esw_b), 32'd0);
        checkOutput("reset_ovf_b", 32'(ovf_b), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(5);

        $display("[TB] single press, no repeat");
        sw_in = 16'hA5C3;
        c = cyc;
        pushEvent(1'b0, 5'b00100, 1'b0, 16'hA5C3, c + LAT);
        applyStimulus(1'b0, 5'b00100);
        tick(30);
        applyStimulus(1'b0, 5'b00000);
        tick(20);

        $display("[TB] glitch rejection then stable press");
        applyStimulus(1'b0, 5'b00001);
        tick(3);
        applyStimulus(1'b0, 5'b00000);
        tick(15);
        c = cyc;
        pushEvent(1'b0, 5'b00001, 1'b0, 16'hA5C3, c + LAT);
        applyStimulus(1'b0, 5'b00001);
        tick(8);
        applyStimulus(1'b0, 5'b00000);
        tick(15);

        $display("[TB] auto-repeat while held");
        sw_in = 16'h1234;
        c = cyc;
        pushEvent(1'b1, 5'b00010, 1'b0, 16'h1234, c + LAT);
        for (int r = 1; r <= 7; r++)
            pushEvent(1'b1, 5'b00010, 1'b1, 16'h1234, c + LAT + RD + RP * (r - 1));
        applyStimulus(1'b1, 5'b00010);
        tick(47);
        applyStimulus(1'b1, 5'b00000);
        tick(30);

        $display("[TB] stalled output with two channels");
        sw_in = 16'h0F0F;
        rdy_b = 1'b0;
        applyStimulus(1'b1, 5'b01000);
        tick(2);
        applyStimulus(1'b1, 5'b01001);
        tick(9);
        applyStimulus(1'b1, 5'b00000);
        sw_in = 16'hF0F0;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(val_b), 32'd1);
            checkOutput("stall_button", 32'(evb_b), 32'(5'b01000));
            checkOutput("stall_sw", 32'(esw_b), 32'(16'h0F0F));
            tick(1);
        end
        k = cyc;
        pushEvent(1'b1, 5'b01000, 1'b0, 16'h0F0F, k);
        pushEvent(1'b1, 5'b00001, 1'b0, 16'hF0F0, k + 1);
        rdy_b = 1'b1;
        tick(5);
        @(negedge clk);
        checkOutput("stall_overflow", 32'(ovf_b), 32'd0);
        tick(20);

        $display("[TB] overflow from repeats while pending");
        sw_in = 16'h5A5A;
        rdy_b = 1'b0;
        c = cyc;
        applyStimulus(1'b1, 5'b00100);
        tick(20);
        @(negedge clk);
        checkOutput("ovf_before_drop", 32'(ovf_b), 32'd0);
        checkOutput("ovf_held_button", 32'(evb_b), 32'(5'b00100));
        tick(7);
        applyStimulus(1'b1, 5'b00000);
        tick(2);
        @(negedge clk);
        checkOutput("ovf_after_drop", 32'(ovf_b), 32'd1);
        tick(1);
        k = cyc;
        pushEvent(1'b1, 5'b00100, 1'b0, 16'h5A5A, k);
        pushEvent(1'b1, 5'b00100, 1'b1, 16'h5A5A, k + 1);
        rdy_b = 1'b1;
        tick(20);
        @(negedge clk);
        checkOutput("ovf_sticky", 32'(ovf_b), 32'd1);
        tick(1);

        $display("[TB] reset in the middle of auto-repeat");
        sw_in = 16'h3C3C;
        c = cyc;
        pushEvent(1'b1, 5'b00010, 1'b0, 16'h3C3C, c + LAT);
        applyStimulus(1'b1, 5'b00010);
        tick(13);
        rdy_b = 1'b0;
        tick(7);
        @(negedge clk);
        checkOutput("pre_rst_valid", 32'(val_b), 32'd1);
        checkOutput("pre_rst_repeat", 32'(rep_b), 32'd1);
        tick(1);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        checkOutput("rst_valid", 32'(val_b), 32'd0);
        checkOutput("rst_button", 32'(evb_b), 32'd0);
        checkOutput("rst_repeat", 32'(rep_b), 32'd0);
        checkOutput("rst_sw", 32'(esw_b), 32'd0);
        checkOutput("rst_overflow", 32'(ovf_b), 32'd0);
        rst   = 1'b0;
        rdy_b = 1'b1;
        pushEvent(1'b1, 5'b00010, 1'b0, 16'h3C3C, cyc + LAT);
        tick(10);
        applyStimulus(1'b1, 5'b00000);
        tick(25);

        checkOutput("queue_a_drained", 32'(q_a.size()), 32'd0);
        checkOutput("queue_b_drained", 32'(q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
